// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM states and operand-signedness decode.
package mdu_pkg;

   typedef enum logic [2:0] {
      OpMul    = 3'd0,
      OpMulh   = 3'd1,
      OpMulhsu = 3'd2,
      OpMulhu  = 3'd3,
      OpDiv    = 3'd4,
      OpDivu   = 3'd5,
      OpRem    = 3'd6,
      OpRemu   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_e;

   function automatic logic is_div(input op_e op);
      return op[2];
   endfunction

   function automatic logic is_rem(input op_e op);
      return (op == OpRem) || (op == OpRemu);
   endfunction

   function automatic logic is_signed_rs1(input op_e op);
      return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
   endfunction

   function automatic logic is_signed_rs2(input op_e op);
      return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Single radix-2 step shared by multiply (shift-add, right shift) and
// divide (restoring shift-subtract, left shift).
module mdu_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   operand,
   input  logic              div_mode,
   output logic [2*XLEN-1:0] acc_next,
   output logic              q_bit
);

   logic [XLEN:0] sum;
   logic [XLEN:0] trial;

   always_comb begin
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
      // Shifted partial remainder needs one extra bit; no borrow means it fits.
      trial    = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
      q_bit    = 1'b0;
      acc_next = '0;
      if (div_mode) begin
         q_bit    = ~trial[XLEN];
         acc_next = {(q_bit ? trial[XLEN-1:0] : acc[2*XLEN-2:XLEN-1]), acc[XLEN-2:0], 1'b0};
      end else begin
         acc_next = {sum, acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: latches operands on start, runs XLEN
// datapath steps, then applies sign correction while presenting the result.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_start,
   input  logic            i_kill,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_Ra,
   input  logic [XLEN-1:0] i_Rb,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result,
   output logic            o_Z
);

   localparam int unsigned CntW = $clog2(XLEN + 1);

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   op_e                 op_q;
   logic                sa_q, sb_q, special_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [XLEN-1:0]     opb_q, res_q;

   op_e                 start_op;
   logic                sa, sb, div_zero, div_ovf, special;
   logic [XLEN-1:0]     mag_a, mag_b, spec_res, fin;
   logic [2*XLEN-1:0]   iter_acc, acc_step, prod;
   logic                iter_q;

   mdu_iter #(.XLEN(XLEN)) u_iter (
      .acc      (acc_q),
      .operand  (opb_q),
      .div_mode (is_div(op_q)),
      .acc_next (iter_acc),
      .q_bit    (iter_q)
   );

   assign acc_step = iter_acc | {{(2*XLEN-1){1'b0}}, iter_q};

   always_comb begin
      start_op = op_e'(i_op);
      sa       = is_signed_rs1(start_op) & i_Ra[XLEN-1];
      sb       = is_signed_rs2(start_op) & i_Rb[XLEN-1];
      mag_a    = sa ? -i_Ra : i_Ra;
      mag_b    = sb ? -i_Rb : i_Rb;
      div_zero = (i_Rb == '0);
      div_ovf  = ((start_op == OpDiv) || (start_op == OpRem)) &&
                 (i_Ra == {1'b1, {(XLEN-1){1'b0}}}) && (&i_Rb);
      special  = is_div(start_op) && (div_zero || div_ovf);
      if (div_zero) spec_res = is_rem(start_op) ? i_Ra : '1;
      else          spec_res = is_rem(start_op) ? '0 : i_Ra;
   end

   // Sign fix-up of the finished magnitudes, valid while in StDone.
   always_comb begin
      prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
      if (special_q)          fin = acc_q[XLEN-1:0];
      else if (is_div(op_q)) begin
         if (is_rem(op_q))    fin = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
         else                 fin = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      end
      else if (op_q == OpMul) fin = prod[XLEN-1:0];
      else                    fin = prod[2*XLEN-1:XLEN];
   end

   assign o_busy   = (state_q != StIdle);
   assign o_done   = (state_q == StDone) && !i_kill;
   assign o_result = o_done ? fin : res_q;
   assign o_Z      = (o_result == '0);

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= OpMul;
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         special_q <= 1'b0;
         acc_q     <= '0;
         opb_q     <= '0;
         res_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_start && !i_kill) begin
                  op_q      <= start_op;
                  sa_q      <= sa;
                  sb_q      <= sb;
                  special_q <= special;
                  cnt_q     <= CntW'(XLEN);
                  if (special) begin
                     acc_q   <= {{XLEN{1'b0}}, spec_res};
                     state_q <= StDone;
                  end else begin
                     acc_q   <= {{XLEN{1'b0}}, (is_div(start_op) ? mag_a : mag_b)};
                     opb_q   <= is_div(start_op) ? mag_b : mag_a;
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               if (i_kill) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else begin
                  acc_q <= acc_step;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CntW'(1)) state_q <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
               cnt_q   <= '0;
               if (!i_kill) res_q <= fin;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: table of RV32M vectors plus hand-written
// sequences for busy-ignore, kill and mid-operation reset.
module tb_mdu;

   logic        clk = 1'b0;
   logic        rstn, start, kill;
   logic [2:0]  op;
   logic [31:0] ra, rb;
   logic        busy, done, z;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[24];

   mdu #(.XLEN(32)) dut (
      .i_clk    (clk),
      .i_rstn   (rstn),
      .i_start  (start),
      .i_kill   (kill),
      .i_op     (op),
      .i_Ra     (ra),
      .i_Rb     (rb),
      .o_busy   (busy),
      .o_done   (done),
      .o_result (result),
      .o_Z      (z)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Returns at the negedge of cycle 1 (start sampled at edge 0), inputs scrambled.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; ra = a; rb = b; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      op    = o ^ 3'b101;
      ra    = ~a;
      rb    = ~b;
   endtask

   task automatic wait_done(input int from, output int cyc);
      cyc = from;
      while (done !== 1'b1 && cyc < from + 100) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic watch(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (done === 1'b1) cnt++;
      end
   endtask

   initial begin
      int cyc;
      int cnt;
      logic [31:0] held;

      vecs[0]  = '{3'd0, 32'd7,         32'd6,         32'd42,        33};
      vecs[1]  = '{3'd0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         33};
      vecs[2]  = '{3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  33};
      vecs[3]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  33};
      vecs[4]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  33};
      vecs[5]  = '{3'd1, 32'h80000000,  32'h80000000,  32'h40000000,  33};
      vecs[6]  = '{3'd0, 32'h12345678,  32'h10,        32'h23456780,  33};
      vecs[7]  = '{3'd4, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  33};
      vecs[8]  = '{3'd6, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  33};
      vecs[9]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
      vecs[10] = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
      vecs[11] = '{3'd4, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  33};
      vecs[12] = '{3'd6, 32'd7,         32'hFFFFFFFE,  32'd1,         33};
      vecs[13] = '{3'd4, 32'h1234,      32'd0,         32'hFFFFFFFF,  1};
      vecs[14] = '{3'd6, 32'h1234,      32'd0,         32'h1234,      1};
      vecs[15] = '{3'd5, 32'h1234,      32'd0,         32'hFFFFFFFF,  1};
      vecs[16] = '{3'd7, 32'h1234,      32'd0,         32'h1234,      1};
      vecs[17] = '{3'd4, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1};
      vecs[18] = '{3'd6, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1};
      vecs[19] = '{3'd5, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  33};
      vecs[20] = '{3'd7, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  33};
      vecs[21] = '{3'd2, 32'h80000000,  32'd2,         32'hFFFFFFFF,  33};
      vecs[22] = '{3'd0, 32'd0,         32'd5,         32'd0,         33};
      vecs[23] = '{3'd4, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         33};

      rstn = 1'b0; start = 1'b0; kill = 1'b0; op = '0; ra = '0; rb = '0;
      repeat (3) @(negedge clk);
      check("reset_busy",   {31'b0, busy}, 32'd0);
      check("reset_done",   {31'b0, done}, 32'd0);
      check("reset_result", result,        32'd0);
      check("reset_z",      {31'b0, z},    32'd1);
      rstn = 1'b1;

      for (int i = 0; i < 24; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(1, cyc);
         check($sformatf("vec%0d_latency", i), cyc, vecs[i].lat);
         check($sformatf("vec%0d_result", i), result, vecs[i].res);
         check($sformatf("vec%0d_z", i), {31'b0, z}, {31'b0, vecs[i].res == 32'd0});
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
         check($sformatf("vec%0d_idle", i), {31'b0, busy}, 32'd0);
         check($sformatf("vec%0d_held", i), result, vecs[i].res);
      end

      // Second start while busy must be ignored.
      issue(3'd0, 32'd7, 32'd6);
      repeat (4) @(negedge clk);
      op = 3'd5; ra = 32'd100; rb = 32'd7; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("busy_ignore_still_busy", {31'b0, busy}, 32'd1);
      wait_done(6, cyc);
      check("busy_ignore_latency", cyc, 33);
      check("busy_ignore_result", result, 32'd42);
      watch(40, cnt);
      check("busy_ignore_single_done", cnt, 0);

      // Kill during CALC at cycle 10, then a fresh op.
      issue(3'd0, 32'd3, 32'd5);
      repeat (9) @(negedge clk);
      kill = 1'b1;
      #1;
      check("kill_calc_no_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      kill = 1'b0;
      check("kill_calc_idle", {31'b0, busy}, 32'd0);
      check("kill_calc_result_kept", result, 32'd42);
      issue(3'd0, 32'd3, 32'd5);
      wait_done(1, cyc);
      check("after_kill_latency", cyc, 33);
      check("after_kill_result", result, 32'd15);

      // Kill in IDLE suppresses a simultaneous start.
      @(negedge clk);
      op = 3'd0; ra = 32'd9; rb = 32'd9; start = 1'b1; kill = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      check("kill_idle_not_busy", {31'b0, busy}, 32'd0);
      watch(40, cnt);
      check("kill_idle_no_done", cnt, 0);

      // Kill during DONE of a one-cycle divide-by-zero.
      issue(3'd4, 32'h1234, 32'd0);
      kill = 1'b1;
      #1;
      check("kill_done_no_done", {31'b0, done}, 32'd0);
      check("kill_done_result_kept", result, 32'd15);
      @(negedge clk);
      kill = 1'b0;
      check("kill_done_idle", {31'b0, busy}, 32'd0);
      check("kill_done_result_still", result, 32'd15);

      // Reset in the middle of an operation.
      issue(3'd0, 32'd7, 32'd6);
      repeat (14) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check("midreset_busy", {31'b0, busy}, 32'd0);
      check("midreset_done", {31'b0, done}, 32'd0);
      check("midreset_result", result, 32'd0);
      check("midreset_z", {31'b0, z}, 32'd1);
      rstn = 1'b1;
      watch(40, cnt);
      check("midreset_no_late_done", cnt, 0);
      held = result;
      check("midreset_result_stays", held, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Iterative multiply/divide unit implementing the RV32M operations. It is the multi-cycle counterpart to the single-cycle integer ALU.
- The decode/execute stage drives operands and a funct3-encoded op with a start pulse. The stage stalls on o_busy and captures o_result on the o_done pulse.
- One shared radix-2 datapath serves both operations: shift-add for multiply, restoring shift-subtract for divide.

Parameters:
- XLEN, 32, operand/result width. Iteration count equals XLEN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_start  in  1  request pulse; sampled only in IDLE.
- i_kill  in  1  pipeline flush; aborts the operation in flight.
- i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_Ra  in  XLEN  rs1 operand (multiplicand/dividend).
- i_Rb  in  XLEN  rs2 operand (multiplier/divisor).
- o_busy  out  1  high in CALC and DONE.
- o_done  out  1  one-cycle pulse; o_result valid in the same cycle.
- o_result  out  XLEN  result; held stable from o_done until the next accepted start.
- o_Z  out  1  o_result == 0.

Behaviour:
- Reset (i_rstn=0 at a clock edge): state IDLE, o_busy=0, o_done=0, o_result=0, counter=0. Reset overrides every other input, including mid-operation.
- States:
  - IDLE, CALC, DONE.
  - IDLE & i_start: latch op and operands, go to CALC with counter=XLEN. Special-case divides go directly to DONE.
  - CALC: one iteration per cycle, counter decrements; when counter reaches 1, go to DONE.
  - DONE: o_done=1, o_result updated, then go to IDLE.
- Latency:
  - Start sampled at edge 0 gives o_done high during cycle XLEN+1 (33 for XLEN=32).
  - Special cases give o_done in cycle 1.
  - A new start is accepted in the cycle after DONE; back-to-back throughput is one op per XLEN+2 cycles.
- i_start while o_busy=1 is ignored, with no queuing.
- Operand/op changes after acceptance have no effect, because all inputs are latched at start.
- Signedness:
  - rs1 is signed for MULH, MULHSU, DIV, REM; rs2 is signed for MULH, DIV, REM.
  - Signed operands are converted to XLEN-bit unsigned magnitudes; abs(-2^(XLEN-1)) = 2^(XLEN-1) fits.
  - Multiply result sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa.
  - Negation is applied in DONE to the 2*XLEN product or to the XLEN quotient/remainder.
- Multiply: 2*XLEN-bit accumulator. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring algorithm, one quotient bit per cycle. The remainder is never negative before sign fix.
- Divide by zero (i_Rb=0):
  - DIV/DIVU give all-ones.
  - REM/REMU give i_Ra.
  - Via the 1-cycle path, no trap.
- Signed overflow (DIV/REM with i_Ra=-2^(XLEN-1), i_Rb=-1): DIV gives -2^(XLEN-1), REM gives 0, via the 1-cycle path.
- i_kill:
  - In CALC or DONE: go to IDLE next edge, o_done forced 0 in that cycle, o_result unchanged.
  - In IDLE: suppresses a simultaneous i_start.
- o_Z is combinational from the o_result register.

Decomposition:
- Shared include MDU_DEFINES.vh, next to ALU_DEFINES.vh: the eight op encodings, state encodings, and the is_div/is_signed_rs1/is_signed_rs2 decode macros.
- One natural sub-module, mdu_iter: combinational single-step datapath.
  - Inputs: accumulator, operand, mode.
  - Output: next accumulator and quotient bit.
- FSM, counter, sign handling and special cases stay in mdu.

Test Plan:
- MUL 7*6: o_done at cycle 33, o_result=42. MUL 0xFFFFFFFF*0xFFFFFFFF: o_result=1, o_Z=0.
- MULH/MULHSU/MULHU on Ra=0xFFFFFFFF, Rb=0xFFFFFFFF give 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
- Signed divide: DIV -7/2 gives 0xFFFFFFFD (-3); REM -7/2 gives 0xFFFFFFFF (-1); DIVU 100/7 gives 14; REMU 100/7 gives 2.
- Divide by zero, Ra=0x1234: DIV gives 0xFFFFFFFF; REM gives 0x1234; o_done in cycle 1. Overflow 0x80000000/-1: DIV gives 0x80000000; REM gives 0 with o_Z=1.
- Start ignored while busy: second i_start at cycle 5 with new operands gives a single o_done at cycle 33 with the first result. i_kill at cycle 10 gives no o_done, o_busy=0 next cycle, and a new start accepted at cycle 12 completing correctly.
- Reset mid-operation: i_rstn=0 at cycle 15 gives o_busy=0, o_done=0, o_result=0 next cycle, and no later o_done from the aborted op.
